// File: rtl/pipe_scroller.sv
// Side-scrolling pipe field: moves pipes left, wraps them, and scores passes.
// Optional macro PIPE_RANDOM_GAP_EN selects LFSR-driven gap heights.
module pipe_scroller #(
    parameter int NUM_PIPES     = 4,
    parameter int X_W           = 11,
    parameter int SCREEN_W      = 640,
    parameter int PIPE_SPACING  = 160,
    parameter int SPEED         = 2,
    parameter int BIRD_X        = 100,
    parameter int SCORE_W       = 8,
    parameter int GAP_W         = 9,
    parameter int GAP_Y_DEFAULT = 200,
    localparam int OP_W         = $clog2(NUM_PIPES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       count_EN,
    input  logic                       Lose,
    input  logic                       restart,
    output logic [NUM_PIPES*X_W-1:0]   pipe_x,
    output logic [NUM_PIPES*GAP_W-1:0] pipe_gap_y,
    output logic [OP_W-1:0]            out_pipe,
    output logic [SCORE_W-1:0]         Score,
    output logic                       frozen
);

    typedef enum logic [1:0] {IDLE, RUN, FROZEN} state_t;

    localparam int PERIOD = NUM_PIPES * PIPE_SPACING;
    localparam logic [X_W-1:0] SPD = X_W'(SPEED);
    localparam logic [X_W-1:0] WRAP_ADD = X_W'(PERIOD - SPEED);
    localparam logic [X_W-1:0] BX = X_W'(BIRD_X);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [OP_W-1:0] LAST = OP_W'(NUM_PIPES - 1);
    localparam logic [GAP_W-1:0] GAP_DEF = GAP_W'(GAP_Y_DEFAULT);

    state_t                   state;
    logic                     ready;
    logic                     step;
    logic                     fz_restart;
    logic                     score_hit;
    logic [NUM_PIPES*X_W-1:0] x_nxt;
    logic [NUM_PIPES-1:0]     wrap;
    logic [X_W-1:0]           xb;
    logic [X_W-1:0]           xa;
    logic [GAP_W-1:0]         gap_new;

    function automatic logic [NUM_PIPES*X_W-1:0] init_x();
        logic [NUM_PIPES*X_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PIPES; i++)
            v[i*X_W +: X_W] = X_W'(SCREEN_W + i * PIPE_SPACING);
        return v;
    endfunction

    assign step       = ready && count_EN && !Lose && (state != FROZEN);
    assign fz_restart = (state == FROZEN) && restart;

    // Next x for every pipe; pipes below SPEED jump one full period right
    always_comb begin
        x_nxt = pipe_x;
        wrap  = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (pipe_x[i*X_W +: X_W] >= SPD) begin
                x_nxt[i*X_W +: X_W] = pipe_x[i*X_W +: X_W] - SPD;
            end else begin
                x_nxt[i*X_W +: X_W] = pipe_x[i*X_W +: X_W] + WRAP_ADD;
                wrap[i] = 1'b1;
            end
        end
    end

    assign xb        = pipe_x[int'(out_pipe)*X_W +: X_W];
    assign xa        = x_nxt[int'(out_pipe)*X_W +: X_W];
    assign score_hit = (xb >= BX) && (xa < BX);

`ifdef PIPE_RANDOM_GAP_EN
    localparam int GAP_MIN   = 120;
    localparam int GAP_RANGE = 240;

    logic [15:0] lfsr;
    logic        fb;

    assign fb      = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign gap_new = GAP_W'(GAP_MIN + int'(lfsr[GAP_W-1:0]) % GAP_RANGE);

    // Fibonacci LFSR advancing once per movement step
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else if (fz_restart) begin
            lfsr <= 16'hACE1;
        end else if (step) begin
            lfsr <= {lfsr[14:0], fb};
        end
    end
`else
    assign gap_new = GAP_DEF;
`endif

    // Release synchroniser: blocks stepping on the first edge after reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ready <= 1'b0;
        else        ready <= 1'b1;
    end

    // Game FSM plus pipe positions, gaps, score and next-pipe pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pipe_x     <= init_x();
            pipe_gap_y <= {NUM_PIPES{GAP_DEF}};
            out_pipe   <= '0;
            Score      <= '0;
            frozen     <= 1'b0;
        end else if (fz_restart) begin
            state      <= IDLE;
            pipe_x     <= init_x();
            pipe_gap_y <= {NUM_PIPES{GAP_DEF}};
            out_pipe   <= '0;
            Score      <= '0;
            frozen     <= 1'b0;
        end else begin
            if (step) begin
                pipe_x <= x_nxt;
                for (int i = 0; i < NUM_PIPES; i++)
                    if (wrap[i]) pipe_gap_y[i*GAP_W +: GAP_W] <= gap_new;
                if (score_hit) begin
                    if (Score != SCORE_MAX) Score <= Score + 1'b1;
                    out_pipe <= (out_pipe == LAST) ? '0 : out_pipe + 1'b1;
                end
            end
            unique case (state)
                IDLE: if (step) state <= RUN;
                RUN: begin
                    if (Lose) begin
                        state  <= FROZEN;
                        frozen <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: position/score model from step count, two builds.
// Instance b uses SCORE_W=2 and an odd start so pipe 0 passes through x=1.
module tb_pipe_scroller;

    localparam int N   = 4;
    localparam int XW  = 11;
    localparam int GW  = 9;
    localparam int SP  = 160;
    localparam int SPD = 2;
    localparam int BX  = 100;
    localparam int P   = N * SP;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic count_EN = 1'b0;
    logic Lose     = 1'b0;
    logic restart  = 1'b0;

    logic [N*XW-1:0] px_a, px_b;
    logic [N*GW-1:0] gy_a, gy_b;
    logic [1:0]      op_a, op_b;
    logic [7:0]      sc_a;
    logic [1:0]      sc_b;
    logic            fz_a, fz_b;

    int checks = 0;
    int errors = 0;

    int m_k     = 0;
    int m_phase = 0;
    int m_rel   = 0;
    int m_cnt[2] = '{0, 0};
    int scr[2]   = '{640, 641};
    int smax[2]  = '{255, 3};

    pipe_scroller dut_a (
        .clk(clk), .reset(reset), .count_EN(count_EN), .Lose(Lose),
        .restart(restart), .pipe_x(px_a), .pipe_gap_y(gy_a),
        .out_pipe(op_a), .Score(sc_a), .frozen(fz_a)
    );

    pipe_scroller #(.SCORE_W(2), .SCREEN_W(641)) dut_b (
        .clk(clk), .reset(reset), .count_EN(count_EN), .Lose(Lose),
        .restart(restart), .pipe_x(px_b), .pipe_gap_y(gy_b),
        .out_pipe(op_b), .Score(sc_b), .frozen(fz_b)
    );

    always #5 clk = ~clk;

    // Position after k steps: straight subtraction until first wrap, then modulo the period
    function automatic int xpos(int s0, int i, int k);
        int d;
        d = s0 + i * SP - SPD * k;
        if (d >= 0) return d;
        return ((d % P) + P) % P;
    endfunction

    function automatic int xa(int i);
        return int'(px_a[i*XW +: XW]);
    endfunction

    function automatic int xb(int i);
        return int'(px_b[i*XW +: XW]);
    endfunction

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1 run, 2 frozen; counts crossings of BIRD_X
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_k = 0; m_phase = 0; m_rel = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            m_rel++;
            if (m_phase == 2) begin
                if (restart) begin
                    m_phase = 0; m_k = 0;
                    m_cnt[0] = 0; m_cnt[1] = 0;
                end
            end else if (Lose) begin
                if (m_phase == 1) m_phase = 2;
            end else if (count_EN && m_rel >= 2) begin
                for (int u = 0; u < 2; u++)
                    for (int i = 0; i < N; i++)
                        if (xpos(scr[u], i, m_k) >= BX &&
                            xpos(scr[u], i, m_k + 1) < BX)
                            m_cnt[u]++;
                m_k++;
                m_phase = 1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            check($sformatf("x_a[%0d]", i), xa(i), xpos(scr[0], i, m_k));
            check($sformatf("x_b[%0d]", i), xb(i), xpos(scr[1], i, m_k));
`ifdef PIPE_RANDOM_GAP_EN
            check($sformatf("gap_a_rng[%0d]", i),
                  int'(gy_a[i*GW +: GW] >= 120 && gy_a[i*GW +: GW] <= 359), 1);
`else
            check($sformatf("gap_a[%0d]", i), int'(gy_a[i*GW +: GW]), 200);
            check($sformatf("gap_b[%0d]", i), int'(gy_b[i*GW +: GW]), 200);
`endif
        end
        check("score_a", int'(sc_a), (m_cnt[0] > smax[0]) ? smax[0] : m_cnt[0]);
        check("score_b", int'(sc_b), (m_cnt[1] > smax[1]) ? smax[1] : m_cnt[1]);
        check("out_a", int'(op_a), m_cnt[0] % N);
        check("out_b", int'(op_b), m_cnt[1] % N);
        check("frozen_a", int'(fz_a), int'(m_phase == 2));
        check("frozen_b", int'(fz_b), int'(m_phase == 2));
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_x0", xa(0), 640);
        check("rst_x3", xa(3), 1120);
        check("rst_score", int'(sc_a), 0);
        check("rst_out", int'(op_a), 0);
        check("rst_frozen", int'(fz_a), 0);

        reset = 1'b1;
        repeat (2) @(negedge clk);
        count_EN = 1'b1;
        repeat (271) @(negedge clk);
        check("s271_score", int'(sc_a), 1);
        check("s271_out", int'(op_a), 1);
        check("s271_x0", xa(0), 98);
        check("s271_x1", xa(1), 258);

        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("run_restart_x0", xa(0), 96);
        check("run_restart_fz", int'(fz_a), 0);

        repeat (48) @(negedge clk);
        check("b_x0_one", xb(0), 1);
        @(negedge clk);
        check("b_x0_wrap", xb(0), 639);
        check("b_spacing", xb(0) - xb(3), 160);
        check("a_x0_wrap", xa(0), 638);

        repeat (279) @(negedge clk);
        check("a_score5", int'(sc_a), 5);
        check("a_out5", int'(op_a), 1);
        check("b_score_sat", int'(sc_b), 3);
        check("b_out5", int'(op_b), 1);

        Lose = 1'b1;
        @(negedge clk);
        Lose = 1'b0;
        check("lose_fz", int'(fz_a), 1);
        check("lose_x0", xa(0), 80);
        repeat (50) @(negedge clk);
        check("hold_fz", int'(fz_a), 1);
        check("hold_x0", xa(0), 80);
        check("hold_score", int'(sc_a), 5);

        count_EN = 1'b0;
        restart  = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("rs_x0", xa(0), 640);
        check("rs_x3", xa(3), 1120);
        check("rs_b_x0", xb(0), 641);
        check("rs_score", int'(sc_a), 0);
        check("rs_out", int'(op_a), 0);
        check("rs_fz", int'(fz_a), 0);

        count_EN = 1'b1;
        repeat (10) @(negedge clk);
        check("idle_step_x0", xa(0), 620);

        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_x0", xa(0), 640);
        check("async_x2", xa(2), 960);
        check("async_b_x0", xb(0), 641);
        check("async_score", int'(sc_a), 0);
        check("async_fz", int'(fz_a), 0);

        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("release_x0", xa(0), 632);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
